// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// state encodings, opcode constants, select codes and the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [1:0] PCS_PC4  = 2'b00;
  localparam logic [1:0] PCS_BEQ  = 2'b01;
  localparam logic [1:0] PCS_BNE  = 2'b10;
  localparam logic [1:0] PCS_JUMP = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
// master: the controller (takes opcode/mem_ready, drives all controls).
// slave : the datapath side.
interface multicycle_control_if #(parameter int COUNT_W = 32);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_source;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic               illegal_op;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, illegal_op, instr_count
  );
endinterface

// File: rtl/mc_ctrl_output_decode.sv
// Combinational control-word decode: state + latched opcode -> control word.
// Ports: state, op_q, mem_ready in; cw (ctrl_t) out.
module mc_ctrl_output_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  output ctrl_t      cw
);
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_4;
        // IR and PC+4 only commit once the instruction word is actually back
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE:   cw.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_R_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = RD_RD;
      end
      S_I_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_I_WB: cw.reg_write = 1'b1;
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALU_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = (op_q == OP_BNE) ? PCS_BNE : PCS_BEQ;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCS_JUMP;
        // JAL links: PC already holds PC+4 after fetch
        if (op_q == OP_JAL) begin
          cw.reg_write  = 1'b1;
          cw.reg_dst    = RD_RA;
          cw.mem_to_reg = M2R_PC;
        end
      end
      default: cw = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset datapath.
// Ports: clk, reset_n (sync, active low), bus (master modport: opcode and
// mem_ready in; all datapath controls, illegal_op pulse, instr_count out).
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  multicycle_control_if.master bus
);
  state_t             state, state_nxt;
  logic [5:0]         op_q;
  logic               illegal_op;
  logic [COUNT_W-1:0] instr_count;
  logic               retire;
  logic               op_bad;
  ctrl_t              cw, cw_o;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      op_q        <= '0;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      state      <= state_nxt;
      illegal_op <= (state == S_DECODE) && op_bad;
      if (state == S_DECODE) op_q <= bus.opcode;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    op_bad    = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_R:          state_nxt = S_R_EXEC;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_ADDI:       state_nxt = S_I_EXEC;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J, OP_JAL:  state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            op_bad    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_nxt = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (bus.mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEM_WRITE: if (bus.mem_ready) begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_R_EXEC: state_nxt = S_R_WB;
      S_I_EXEC: state_nxt = S_I_WB;
      S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  mc_ctrl_output_decode u_dec (
    .state     (state),
    .op_q      (op_q),
    .mem_ready (bus.mem_ready),
    .cw        (cw)
  );

  // Reset blanks everything combinationally so an abandoned write dies at once
  assign cw_o = reset_n ? cw : '0;

  assign bus.pc_write      = cw_o.pc_write;
  assign bus.pc_write_cond = cw_o.pc_write_cond;
  assign bus.pc_source     = cw_o.pc_source;
  assign bus.iord          = cw_o.iord;
  assign bus.mem_read      = cw_o.mem_read;
  assign bus.mem_write     = cw_o.mem_write;
  assign bus.ir_write      = cw_o.ir_write;
  assign bus.reg_write     = cw_o.reg_write;
  assign bus.reg_dst       = cw_o.reg_dst;
  assign bus.mem_to_reg    = cw_o.mem_to_reg;
  assign bus.alu_src_a     = cw_o.alu_src_a;
  assign bus.alu_src_b     = cw_o.alu_src_b;
  assign bus.alu_op        = cw_o.alu_op;
  assign bus.illegal_op    = illegal_op;
  assign bus.instr_count   = instr_count;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed plan followed by random instruction
// streams, checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;
  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  multicycle_control_if #(.COUNT_W(32)) bus ();

  multicycle_control #(.COUNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction phases, as the programmer sees an instruction progress
  localparam int PH_RST = 0, PH_FETCH = 1, PH_DECODE = 2, PH_ADDR = 3,
                 PH_LOAD = 4, PH_LWB = 5, PH_STORE = 6, PH_REXEC = 7,
                 PH_RWB = 8, PH_IEXEC = 9, PH_IWB = 10, PH_BR = 11, PH_JMP = 12;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         J = 6'b000010, JAL = 6'b000011;

  logic [31:0] cnt_m;   // model retired count
  bit          ill_m;   // model illegal_op

  function automatic logic [17:0] get_cw();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord,
            bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op};
  endfunction

  function automatic logic [17:0] exp_cw(int ph, logic [5:0] op, bit mr);
    logic pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, sa = 0;
    logic [1:0] pcs = 0, rdst = 0, m2r = 0, sb = 0, aop = 0;
    case (ph)
      PH_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      PH_DECODE: sb = 2'b11;
      PH_ADDR:   begin sa = 1; sb = 2'b10; end
      PH_LOAD:   begin mrd = 1; iord = 1; end
      PH_LWB:    begin rw = 1; m2r = 2'b01; end
      PH_STORE:  begin mwr = 1; iord = 1; end
      PH_REXEC:  begin sa = 1; aop = 2'b10; end
      PH_RWB:    begin rw = 1; rdst = 2'b01; end
      PH_IEXEC:  begin sa = 1; sb = 2'b10; end
      PH_IWB:    rw = 1;
      PH_BR:     begin sa = 1; aop = 2'b01; pwc = 1; pcs = (op == BNE) ? 2'b10 : 2'b01; end
      PH_JMP:    begin
        pw = 1; pcs = 2'b11;
        if (op == JAL) begin rw = 1; rdst = 2'b10; m2r = 2'b10; end
      end
      default: ;
    endcase
    return {pw, pwc, pcs, iord, mrd, mwr, irw, rw, rdst, m2r, sa, sb, aop};
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {R, LW, SW, BEQ, BNE, ADDI, J, JAL};
  endfunction

  // One clock cycle; called right at a rising edge. Opcode is the real one
  // only in DECODE; elsewhere it is noise the controller must ignore.
  task automatic step(int ph, logic [5:0] op, bit mr, bit rn);
    logic [17:0] e;
    #1;
    reset_n       = rn;
    bus.mem_ready = mr;
    bus.opcode    = (ph == PH_DECODE) ? op : 6'($urandom);
    e = exp_cw(ph, op, mr);
    @(negedge clk);
    checks++;
    assert (get_cw() === e) else begin
      failures++;
      $error("FAIL ctrl ph=%0d op=%b actual=%h required=%h", ph, op, get_cw(), e);
    end
    checks++;
    assert (bus.illegal_op === ill_m) else begin
      failures++;
      $error("FAIL illegal_op ph=%0d actual=%b required=%b", ph, bus.illegal_op, ill_m);
    end
    checks++;
    assert (bus.instr_count === cnt_m) else begin
      failures++;
      $error("FAIL instr_count ph=%0d actual=%0d required=%0d", ph, bus.instr_count, cnt_m);
    end
    ill_m = 0;
    @(posedge clk);
  endtask

  // Whole instruction: fw fetch waits, mw data-memory waits.
  task automatic run_instr(logic [5:0] op, int fw, int mw);
    for (int i = 0; i < fw; i++) step(PH_FETCH, op, 0, 1);
    step(PH_FETCH, op, 1, 1);
    step(PH_DECODE, op, 1'($urandom), 1);
    case (op)
      R:    begin step(PH_REXEC, op, 1'($urandom), 1); step(PH_RWB, op, 1'($urandom), 1); end
      ADDI: begin step(PH_IEXEC, op, 1'($urandom), 1); step(PH_IWB, op, 1'($urandom), 1); end
      LW: begin
        step(PH_ADDR, op, 1'($urandom), 1);
        for (int i = 0; i < mw; i++) step(PH_LOAD, op, 0, 1);
        step(PH_LOAD, op, 1, 1);
        step(PH_LWB, op, 1'($urandom), 1);
      end
      SW: begin
        step(PH_ADDR, op, 1'($urandom), 1);
        for (int i = 0; i < mw; i++) step(PH_STORE, op, 0, 1);
        step(PH_STORE, op, 1, 1);
      end
      BEQ, BNE: step(PH_BR, op, 1'($urandom), 1);
      J, JAL:   step(PH_JMP, op, 1'($urandom), 1);
      default:  ill_m = 1;
    endcase
    if (legal(op)) cnt_m = cnt_m + 1;
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{R, LW, SW, BEQ, BNE, ADDI, J, JAL};
    cnt_m = 0;
    ill_m = 0;
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = '0;

    // reset held for two cycles, then released into FETCH
    @(posedge clk);
    step(PH_RST, 6'd0, 1, 0);
    step(PH_RST, 6'd0, 1, 0);

    // directed plan
    run_instr(LW, 0, 2);
    run_instr(BEQ, 0, 0);
    run_instr(BNE, 0, 0);
    run_instr(JAL, 0, 0);
    run_instr(J, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(R, 1, 0);
    run_instr(ADDI, 0, 0);
    run_instr(SW, 2, 1);

    // random instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 7)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // reset during a store wait: write strobe drops at once, no retire
    step(PH_FETCH, SW, 1, 1);
    step(PH_DECODE, SW, 1, 1);
    step(PH_ADDR, SW, 1, 1);
    step(PH_STORE, SW, 0, 1);
    step(PH_RST, SW, 0, 0);
    cnt_m = 0;
    run_instr(ADDI, 0, 0);
    run_instr(SW, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle MIPS-subset datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath mux selects, write enables and the 2-bit PC-source code consumed by the PC source controller (00 PC+4, 01 BEQ, 10 BNE, 11 J/JAL).
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
COUNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
opcode  in  6  instruction[31:26] from IR; valid from the DECODE cycle onward
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  conditional PC load (branch)
pc_source  out  2  PC-source code: 00 PC+4, 01 BEQ, 10 BNE, 11 jump
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_write  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
illegal_op  out  1  one-cycle pulse: unsupported opcode seen
instr_count  out  COUNT_W  retired-instruction count

Behaviour:
- State register, 4-bit encoding. States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, J 000010, JAL 000011.
- Reset, when reset_n=0 at a clk edge: state=FETCH, op_q=0, instr_count=0, illegal_op=0. While reset_n=0, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced 0. All selects reset to 0.
- Strobes and selects are Moore outputs of the state. Exceptions: ir_write and pc_write in FETCH are additionally gated by mem_ready.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are 1 only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). op_q<=opcode. Next state:
  - R -> R_EXEC
  - LW/SW -> MEM_ADDR
  - ADDI -> I_EXEC
  - BEQ/BNE -> BRANCH
  - J/JAL -> JUMP
  - other -> FETCH, with illegal_op=1 in the next cycle only; instr_count unchanged.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_READ if op_q=LW, else MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Next FETCH.
- MEM_WRITE: mem_write=1, iord=1. Hold until mem_ready, then go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1. pc_source=01 if op_q=BEQ, 10 if BNE. Next FETCH.
- JUMP: pc_write=1, pc_source=11. If op_q=JAL, also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). Next FETCH.
- instr_count increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH or JUMP. It wraps modulo 2^COUNT_W.
- Cycles per instruction with mem_ready always 1: LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J/JAL 3. Each memory wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- A reset asserted mid-instruction abandons the instruction: no write strobe fires and no count increment occurs.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - PC-source codes (00/01/10/11)
  - alu_op codes
  - reg_dst, mem_to_reg and alu_src_b select codes
- One sub-module, mc_ctrl_output_decode: purely combinational state+op_q -> control-word decode. The parent keeps the state register, next-state logic, op_q, illegal_op and the counter.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles, then release with mem_ready=1 -> all strobes 0 during reset; first cycle after release is FETCH with mem_read=1, ir_write=1, pc_write=1, pc_source=00; instr_count=0.
2. LW with mem_ready low for 2 cycles in MEM_READ, opcode=100011 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ×3, MEM_WB, FETCH; reg_write=1 with mem_to_reg=01 for exactly one cycle; instr_count 0->1.
3. BEQ 000100 then BNE 000101 -> BRANCH asserts pc_write_cond=1, with pc_source=01 for BEQ and 10 for BNE; each takes 3 cycles; count +2.
4. JAL 000011 -> JUMP cycle has pc_write=1, pc_source=11, reg_write=1, reg_dst=10, mem_to_reg=10. J 000010 has reg_write=0.
5. Illegal opcode 111111 -> DECODE returns to FETCH; illegal_op=1 for exactly one cycle; instr_count unchanged.
6. Assert reset_n=0 during the MEM_WRITE wait -> mem_write drops in the same cycle; state returns to FETCH; instr_count=0.
